// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad entry block.
// The key layout table lives here so a different keypad can be remapped without touching the FSM.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   localparam logic [3:0] ROW_RESET  = 4'b1110;
   localparam logic [3:0] CLEAR_CODE = 4'hF;

   // Indexed by {row, col}; row 0 is the row driven by row_n[0].
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h0, 4'h1, 4'h2, 4'h3,
      4'h4, 4'h5, 4'h6, 4'h7,
      4'h8, 4'h9, 4'hA, 4'hB,
      4'hC, 4'hD, 4'hE, 4'hF
   };

   function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
      return KEY_MAP[{row, col}];
   endfunction

   // Lowest-index active-low column; only meaningful when at least one column is low.
   function automatic logic [1:0] low_col(input logic [3:0] cols);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!cols[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// Used as the keypad scan/sample time base.
module keypad_tick_gen #(
   parameter int unsigned DIV = 100_000
) (
   input  logic CP,
   input  logic RST_N,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge CP or negedge RST_N) begin
      if (!RST_N) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce feeding an 8-digit hex entry register.
// Define KEYPAD_CLEAR_KEY_EN to make key F clear the entry register instead of shifting in.
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int unsigned CLK_HZ         = 100_000_000,
   parameter int unsigned SCAN_HZ        = 1000,
   parameter int unsigned DEBOUNCE_TICKS = 16
) (
   input  logic        CP,
   input  logic        RST_N,
   input  logic [3:0]  col_n,
   output logic [3:0]  row_n,
   output logic [31:0] DATA,
   output logic [3:0]  key_code,
   output logic        key_valid
);

   localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
   localparam int unsigned DW  = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS);

   logic          tick;
   logic [3:0]    col_p0, col_p1;
   state_t        state, state_nx;
   logic [1:0]    row_idx, row_idx_nx;
   logic [1:0]    lat_col, lat_col_nx;
   logic [DW-1:0] cnt, cnt_nx, cnt_inc;
   logic          accept;
   logic [3:0]    accept_code;
   logic [31:0]   data_nx;

   keypad_tick_gen #(.DIV(DIV)) u_tick (
      .CP   (CP),
      .RST_N(RST_N),
      .tick (tick)
   );

   // Stage p0/p1: bring the asynchronous column pins into the CP domain.
   always_ff @(posedge CP or negedge RST_N) begin
      if (!RST_N) begin
         col_p0 <= 4'hF;
         col_p1 <= 4'hF;
      end else begin
         col_p0 <= col_n;
         col_p1 <= col_p0;
      end
   end

   always_ff @(posedge CP or negedge RST_N) begin
      if (!RST_N) state <= SCAN;
      else        state <= state_nx;
   end

   assign cnt_inc = cnt + 1'b1;

   // One shared counter: press-stability count in DEBOUNCE, release count in HELD.
   always_comb begin
      state_nx   = state;
      row_idx_nx = row_idx;
      lat_col_nx = lat_col;
      cnt_nx     = cnt;
      accept     = 1'b0;
      if (tick) begin
         case (state)
            SCAN: begin
               if (col_p1 != 4'hF) begin
                  lat_col_nx = low_col(col_p1);
                  cnt_nx     = '0;
                  state_nx   = DEBOUNCE;
               end else begin
                  row_idx_nx = row_idx + 1'b1;
               end
            end
            DEBOUNCE: begin
               if (!col_p1[lat_col]) begin
                  if (cnt_inc == DB_LAST) begin
                     accept   = 1'b1;
                     cnt_nx   = '0;
                     state_nx = HELD;
                  end else begin
                     cnt_nx = cnt_inc;
                  end
               end else begin
                  state_nx = SCAN;
               end
            end
            HELD: begin
               if (col_p1 == 4'hF) begin
                  if (cnt_inc == DB_LAST) begin
                     cnt_nx   = '0;
                     state_nx = SCAN;
                  end else begin
                     cnt_nx = cnt_inc;
                  end
               end else begin
                  cnt_nx = '0;
               end
            end
            default: state_nx = SCAN;
         endcase
      end
   end

   // Row is frozen outside SCAN, so row_idx doubles as the latched row.
   assign accept_code = key_lookup(row_idx, lat_col);

`ifdef KEYPAD_CLEAR_KEY_EN
   assign data_nx = (accept_code == CLEAR_CODE) ? 32'h0 : {DATA[27:0], accept_code};
`else
   assign data_nx = {DATA[27:0], accept_code};
`endif

   always_ff @(posedge CP or negedge RST_N) begin
      if (!RST_N) begin
         row_idx   <= 2'd0;
         row_n     <= ROW_RESET;
         lat_col   <= 2'd0;
         cnt       <= '0;
         key_valid <= 1'b0;
         key_code  <= 4'h0;
         DATA      <= 32'h0;
      end else begin
         row_idx   <= row_idx_nx;
         row_n     <= ~(4'b0001 << row_idx_nx);
         lat_col   <= lat_col_nx;
         cnt       <= cnt_nx;
         key_valid <= accept;
         if (accept) begin
            key_code <= accept_code;
            DATA     <= data_nx;
         end
      end
   end

endmodule

// File: tb/tb_keypad_entry.sv
// Randomized self-checking bench for keypad_entry with an ideal 4x4 key matrix model.
// Honors KEYPAD_CLEAR_KEY_EN the same way the design does.
module tb_keypad_entry;
   import keypad_pkg::*;

   localparam int unsigned CLK_HZ  = 10;
   localparam int unsigned SCAN_HZ = 1;
   localparam int unsigned DT      = 4;

   logic        CP = 1'b0;
   logic        RST_N = 1'b0;
   logic [3:0]  col_n;
   logic [3:0]  row_n;
   logic [31:0] DATA;
   logic [3:0]  key_code;
   logic        key_valid;

   logic [15:0] pressed = '0;
   logic [31:0] model_data = 32'h0;
   int total = 0;
   int bad = 0;
   int vcount = 0;

   always #5 CP = ~CP;

   keypad_entry #(
      .CLK_HZ        (CLK_HZ),
      .SCAN_HZ       (SCAN_HZ),
      .DEBOUNCE_TICKS(DT)
   ) dut (
      .CP       (CP),
      .RST_N    (RST_N),
      .col_n    (col_n),
      .row_n    (row_n),
      .DATA     (DATA),
      .key_code (key_code),
      .key_valid(key_valid)
   );

   // Ideal switch matrix: a pressed key shorts its column to its row.
   always_comb begin
      col_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
   end

   always @(negedge CP) if (key_valid === 1'b1) vcount <= vcount + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_next(input logic [31:0] d, input int code);
`ifdef KEYPAD_CLEAR_KEY_EN
      if (code == 15) return 32'h0;
`endif
      return {d[27:0], 4'(code)};
   endfunction

   function automatic logic [3:0] rot(input logic [3:0] r);
      return {r[2:0], r[3]};
   endfunction

   task automatic wait_cp(input int n);
      repeat (n) @(negedge CP);
   endtask

   task automatic key_trial(input int code, input int hold_cp, input int other,
                            input bit expect_acc, input string tag);
      int v0;
      v0 = vcount;
      pressed[code] = 1'b1;
      if (other >= 0) begin
         wait_cp(100);
         pressed[other] = 1'b1;
         wait_cp(20);
         pressed[other] = 1'b0;
         wait_cp(hold_cp - 120);
      end else begin
         wait_cp(hold_cp);
      end
      pressed[code] = 1'b0;
      wait_cp(80);
      chk({tag, "_pulses"}, 32'(vcount - v0), expect_acc ? 32'd1 : 32'd0);
      if (expect_acc) begin
         model_data = ref_next(model_data, code);
         chk({tag, "_code"}, {28'h0, key_code}, 32'(code));
      end
      chk({tag, "_data"}, DATA, model_data);
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      wait_cp(3);
      RST_N = 1'b1;
      model_data = 32'h0;
      wait_cp(2);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int v0;
      int steps;
      bit found;
      logic [3:0] prev_row;

      wait_cp(3);
      chk("rst_row", {28'h0, row_n}, 32'h0000_000E);
      chk("rst_data", DATA, 32'h0);
      chk("rst_code", {28'h0, key_code}, 32'h0);
      chk("rst_valid", {31'h0, key_valid}, 32'h0);
      RST_N = 1'b1;

      // Idle scanning: one left rotation every tick period.
      for (int i = 0; i < 8; i++) begin
         prev_row = row_n;
         wait_cp(CLK_HZ / SCAN_HZ);
         chk($sformatf("idle_rot%0d", i), {28'h0, row_n}, {28'h0, rot(prev_row)});
      end
      chk("idle_valid", 32'(vcount), 32'd0);
      chk("idle_data", DATA, 32'h0);

      // Key 6 (row1/col2) pressed as row 1 becomes active, held 8 ticks.
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         if (row_n == 4'b1101) found = 1'b1;
         else wait_cp(1);
      end
      chk("row1_seen", {31'h0, found}, 32'd1);
      key_trial(6, 80, -1, 1'b1, "k6");
      chk("k6_const", DATA, 32'h0000_0006);

      // Bounce on key 0: 2 ticks low, 1 tick high, 2 ticks low.
      v0 = vcount;
      pressed[0] = 1'b1; wait_cp(20);
      pressed[0] = 1'b0; wait_cp(10);
      pressed[0] = 1'b1; wait_cp(20);
      pressed[0] = 1'b0; wait_cp(40);
      chk("bounce_pulses", 32'(vcount - v0), 32'd0);
      chk("bounce_data", DATA, model_data);
      for (int i = 0; i < 2; i++) begin
         prev_row = row_n;
         wait_cp(CLK_HZ / SCAN_HZ);
         chk($sformatf("bounce_rot%0d", i), {28'h0, row_n}, {28'h0, rot(prev_row)});
      end

      // Keys 1..8 then 9.
      for (int k = 1; k <= 8; k++) key_trial(k, 150, -1, 1'b1, $sformatf("seq%0d", k));
      chk("seq8_const", DATA, 32'h1234_5678);
      key_trial(9, 150, -1, 1'b1, "seq9");
      chk("seq9_const", DATA, 32'h2345_6789);

      // Reset in the middle of debouncing key 5.
      v0 = vcount;
      pressed[5] = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 120 && !found; i++) begin
         if (dut.state == DEBOUNCE) found = 1'b1;
         else wait_cp(1);
      end
      chk("k5_reach_debounce", {31'h0, found}, 32'd1);
      wait_cp(15);
      RST_N = 1'b0;
      wait_cp(1);
      chk("midrst_row", {28'h0, row_n}, 32'h0000_000E);
      chk("midrst_data", DATA, 32'h0);
      chk("midrst_code", {28'h0, key_code}, 32'h0);
      chk("midrst_valid", {31'h0, key_valid}, 32'h0);
      pressed[5] = 1'b0;
      wait_cp(3);
      RST_N = 1'b1;
      model_data = 32'h0;
      wait_cp(20);
      chk("midrst_pulses", 32'(vcount - v0), 32'd0);
      key_trial(5, 160, -1, 1'b1, "k5_again");

      // Clear key behaviour.
      do_reset();
      key_trial(10, 150, -1, 1'b1, "clrA");
      key_trial(11, 150, -1, 1'b1, "clrB");
      chk("clr_pre", DATA, 32'h0000_00AB);
      key_trial(15, 150, -1, 1'b1, "clrF");
`ifdef KEYPAD_CLEAR_KEY_EN
      chk("clr_const", DATA, 32'h0);
`else
      chk("clr_const", DATA, 32'h0000_0ABF);
`endif

      // Randomized presses: short glitches, clean holds, and holds with a second key rolled over.
      for (int t = 0; t < 24; t++) begin
         int code, kind, other;
         code = int'($urandom_range(0, 15));
         kind = int'($urandom_range(0, 3));
         wait_cp(int'($urandom_range(0, 9)));
         if (kind == 0) begin
            key_trial(code, int'($urandom_range(1, 25)), -1, 1'b0, $sformatf("rnd%0d_short", t));
         end else if (kind == 1) begin
            other = (code + int'($urandom_range(1, 15))) % 16;
            key_trial(code, int'($urandom_range(150, 200)), other, 1'b1, $sformatf("rnd%0d_roll", t));
         end else begin
            key_trial(code, int'($urandom_range(140, 200)), -1, 1'b1, $sformatf("rnd%0d_long", t));
         end
      end

      steps = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Input-side counterpart to the 8-digit seven-segment display driver. It scans a 4x4 matrix keypad by driving rows low one at a time and sampling the columns, then debounces each press. Every accepted key is shifted into a 32-bit, 8-hex-digit entry register. That register connects directly to the display driver's 32-bit DATA input, so typed digits appear on the display right-to-left.

## Interface
- CLK_HZ, 100_000_000: CP frequency in Hz.
- SCAN_HZ, 1000: row-advance / sample tick rate.
- DEBOUNCE_TICKS, 16: consecutive stable ticks required to accept a press or a release.
- CP  input  1  system clock; all logic on posedge CP.
- RST_N  input  1  reset; one clock; reset is asynchronous and active-low.
- col_n  input  4  keypad columns, active-low (pulled up off-chip), asynchronous.
- row_n  output  4  keypad row drive, active-low, exactly one bit low at all times.
- DATA  output  32  entry register, nibble 0 = most recent key.
- key_code  output  4  code of the last accepted key.
- key_valid  output  1  one-CP pulse when a key is accepted.

## Operation
- Tick divider: counter 0..CLK_HZ/SCAN_HZ-1; tick = one-CP pulse at terminal count, then wrap to 0.
- col_n passes through a 2-flop synchronizer. Decisions use the synchronized value, sampled on tick only.
- Key code = row_index*4 + col_index (row 0 = row_n[0]). Mapping comes from the package table so layouts can be remapped.
- FSM states:
  - SCAN: on tick, if any synchronized column is low, latch row and lowest-index low column, clear debounce count, go to DEBOUNCE. Otherwise rotate row_n left (1110→1101→1011→0111→1110).
  - DEBOUNCE: row frozen. On tick, if the latched column is low, increment the count. If the latched column is high, return to SCAN (row not advanced that tick). When the count reaches DEBOUNCE_TICKS, accept the key and go to HELD.
  - Accept: key_valid=1 for one CP, key_code=latched code, DATA <= {DATA[27:0], code}. The oldest nibble is discarded.
  - HELD: row frozen. On tick, if all columns are high, increment the release count; any low column clears it. When the release count reaches DEBOUNCE_TICKS, go to SCAN.
- Only one key is tracked. Other keys pressed while in DEBOUNCE or HELD are ignored, with no rollover.
- An auto-repeat-free hold produces exactly one key_valid.

## Timing
- Reset values: row_n=4'b1110, DATA=32'h0, key_code=4'h0, key_valid=0, FSM=SCAN, all counters 0.
- Reset asserted mid-operation returns everything to reset values immediately. No key_valid is emitted for an interrupted debounce.
- Acceptance latency: DEBOUNCE_TICKS ticks after the first tick that sees the press, plus the 2-CP synchronizer delay from the pin.
- DATA and key_code update on the same CP edge on which key_valid rises. Both hold until the next accept.
- Release-to-rescan latency: DEBOUNCE_TICKS ticks.
- Row change happens on a tick edge. Columns settle for a full tick period before the next sample.

## Configuration
- KEYPAD_CLEAR_KEY_EN defined:
  - Key code 4'hF is a clear key: accepting it sets DATA=32'h0 instead of shifting.
  - key_valid still pulses and key_code=4'hF.
- KEYPAD_CLEAR_KEY_EN undefined: 4'hF shifts in like any other digit.

## Structure
- Package keypad_pkg holds:
  - FSM state enum (SCAN, DEBOUNCE, HELD).
  - KEY_MAP 16-entry row/col→code constant.
  - CLEAR_CODE = 4'hF.
  - Row reset pattern 4'b1110.
- One natural sub-module, keypad_tick_gen: the CLK_HZ/SCAN_HZ divider producing the tick pulse. It is reusable alongside the display driver's 1 kHz divider.
- Synchronizer, FSM and entry register stay in keypad_entry.

## Test plan
Bench parameters: CLK_HZ/SCAN_HZ=10, DEBOUNCE_TICKS=4.
- Reset, no keys: row_n cycles 1110,1101,1011,0111 every 10 CP; DATA=0, key_valid never high.
- Hold row1/col2 low for 8 ticks: exactly one key_valid, key_code=4'h6, DATA=32'h0000_0006.
- Bounce row0/col0 low 2 ticks, high, low 2 ticks (glitches): no key_valid, FSM returns to SCAN, row scanning resumes.
- Press keys 1,2,…,8 then 9, each with full release: DATA=32'h1234_5678 after the eighth key, then 32'h2345_6789.
- Assert RST_N low during DEBOUNCE of key 5: no key_valid; outputs at reset values; after release of reset, a new press of key 5 is accepted normally.
- With KEYPAD_CLEAR_KEY_EN, DATA=32'h0000_00AB, press key F: key_valid, key_code=4'hF, DATA=32'h0. Without the macro the same press gives DATA=32'h0000_0ABF.
